// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with row synchronizer, per-tick debounce,
// single-cycle key events and a four-digit BCD entry register.
module keypad_scanner #(
  parameter int unsigned CLK_DIV  = 312500,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit4,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_s;
  logic [1:0]         r_col_idx;
  logic [3:0]         r_col_out;
  logic [1:0]         r_row_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_key_code;
  logic               r_key_valid;
  logic               r_key_held;
  logic [15:0]        r_digits;

  logic               w_tick;
  logic [1:0]         w_first_row;
  logic [1:0]         w_col_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_cnt_done;
  logic               w_row_low;
  logic [3:0]         w_code;

  assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_col_next = r_col_idx + 2'd1;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_done = (w_cnt_inc == CNT_W'(DEBOUNCE));
  assign w_row_low  = ~r_row_s[r_row_idx];
  assign w_code     = {r_row_idx, r_col_idx};

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    w_first_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_s[i]) w_first_row = 2'(i);
    end
  end

  // Free-running scan tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= 4'hF;
      r_row_s    <= 4'hF;
    end else begin
      r_row_meta <= row_in;
      r_row_s    <= r_row_meta;
    end
  end

  // Scan / debounce FSM; col_out is kept as a registered one-cold copy of col_idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_SCAN;
      r_col_idx   <= 2'd0;
      r_col_out   <= 4'b1110;
      r_row_idx   <= 2'd0;
      r_cnt       <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_digits    <= 16'd0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (r_row_s != 4'hF) begin
              r_row_idx <= w_first_row;
              r_cnt     <= '0;
              r_state   <= S_DEBOUNCE;
            end else begin
              r_col_idx <= w_col_next;
              r_col_out <= ~(4'b0001 << w_col_next);
            end
          end
          S_DEBOUNCE: begin
            if (w_row_low) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_done) begin
                r_state     <= S_PRESSED;
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                if (w_code <= 4'd9) begin
                  r_digits <= {r_digits[11:0], w_code};
                end else if (w_code == 4'hF) begin
                  r_digits <= 16'd0;
                end
              end
            end else begin
              r_state   <= S_SCAN;
              r_col_idx <= w_col_next;
              r_col_out <= ~(4'b0001 << w_col_next);
            end
          end
          S_PRESSED: begin
            if (!w_row_low) begin
              r_cnt   <= '0;
              r_state <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (!w_row_low) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_done) begin
                r_state    <= S_SCAN;
                r_key_held <= 1'b0;
                r_col_idx  <= w_col_next;
                r_col_out  <= ~(4'b0001 << w_col_next);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= S_PRESSED;
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign digit4    = r_digits[15:12];
  assign digit3    = r_digits[11:8];
  assign digit2    = r_digits[7:4];
  assign digit1    = r_digits[3:0];

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a behavioural keypad drives rows from col_out,
// expected key events are queued at press time and popped on each key_valid.
module tb_keypad_scanner;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEB     = 3;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] digits;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [3:0]  digit4, digit3, digit2, digit1;
  logic [15:0] w_digits;
  logic [15:0] press_mask;
  logic [15:0] m_digits;

  exp_t sb_q[$];
  int   checks;
  int   failures;
  int   n_valid;

  keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEB)) u_dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1)
  );

  assign w_digits = {digit4, digit3, digit2, digit1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: pressed key {r,c} pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_key(input logic [3:0] code);
    exp_t e;
    if (code <= 4'd9) m_digits = {m_digits[11:0], code};
    else if (code == 4'hF) m_digits = 16'd0;
    e.code   = code;
    e.digits = m_digits;
    sb_q.push_back(e);
  endtask

  task automatic wait_held(input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (key_held !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(key_held), 32'(val));
  endtask

  task automatic press_key(input logic [3:0] code, input int hold);
    int v0;
    v0 = n_valid;
    push_key(code);
    @(negedge clk);
    press_mask[code] = 1'b1;
    wait_held(1'b1, 200, "held_set");
    repeat (hold) @(negedge clk);
    press_mask[code] = 1'b0;
    wait_held(1'b0, 100, "held_clr");
    check_eq("valid_once", 32'(n_valid - v0), 32'd1);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (rst && key_valid) begin
      n_valid++;
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("key_code", 32'(key_code), 32'(e.code));
        check_eq("digits", 32'(w_digits), 32'(e.digits));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c0;
    logic [3:0] exp_cols [5];
    int         n;
    int         v0;
    checks     = 0;
    failures   = 0;
    n_valid    = 0;
    m_digits   = 16'd0;
    press_mask = 16'd0;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset mid-scan, then verify column rotation.
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_col", 32'(col_out), 32'h0000000E);
    check_eq("rst_valid", 32'(key_valid), 32'd0);
    check_eq("rst_held", 32'(key_held), 32'd0);
    check_eq("rst_digits", 32'(w_digits), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_cols[0] = 4'b1110; exp_cols[1] = 4'b1101; exp_cols[2] = 4'b1011;
    exp_cols[3] = 4'b0111; exp_cols[4] = 4'b1110;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("col_seq", 32'(col_out), 32'(exp_cols[i]));
      repeat (4) @(posedge clk);
      #1;
    end

    // Row1/col2 held for 20 ticks.
    press_key(4'd6, 80);
    check_eq("digit1_6", 32'(digit1), 32'd6);
    c0 = col_out;
    n = 0;
    while (col_out == c0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check_eq("scan_resume", 32'(col_out != c0), 32'd1);

    // One-tick bounce on row0 under column 1.
    v0 = n_valid;
    n = 0;
    while (col_out == 4'b1101 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (col_out != 4'b1101 && n < 40) begin @(negedge clk); n++; end
    check_eq("bounce_col1", 32'(col_out), 32'h0000000D);
    press_mask[1] = 1'b1;
    repeat (4) @(negedge clk);
    press_mask[1] = 1'b0;
    n = 0;
    while (col_out == 4'b1101 && n < 40) begin @(negedge clk); n++; end
    check_eq("bounce_next_col", 32'(col_out), 32'h0000000B);
    check_eq("bounce_no_valid", 32'(n_valid - v0), 32'd0);
    check_eq("bounce_digits", 32'(w_digits), 32'(m_digits));

    // Entry sequence 1,2,3,6 then A then F.
    press_key(4'd1, 20);
    press_key(4'd2, 20);
    press_key(4'd3, 20);
    press_key(4'd6, 20);
    check_eq("entry_1236", 32'(w_digits), 32'h00001236);
    press_key(4'hA, 20);
    check_eq("key_a_digits", 32'(w_digits), 32'h00001236);
    press_key(4'hF, 20);
    check_eq("key_f_clear", 32'(w_digits), 32'd0);

    // Rows 1 and 3 under column 0; row 1 wins, row 3 release ignored.
    v0 = n_valid;
    push_key(4'd4);
    @(negedge clk);
    press_mask[4]  = 1'b1;
    press_mask[12] = 1'b1;
    wait_held(1'b1, 200, "multi_held");
    repeat (20) @(negedge clk);
    press_mask[12] = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("multi_still_held", 32'(key_held), 32'd1);
    press_mask[4] = 1'b0;
    wait_held(1'b0, 100, "multi_clr");
    check_eq("multi_valid_once", 32'(n_valid - v0), 32'd1);

    // One-tick release chatter while pressed.
    v0 = n_valid;
    push_key(4'd7);
    @(negedge clk);
    press_mask[7] = 1'b1;
    wait_held(1'b1, 200, "chat_held");
    repeat (8) @(negedge clk);
    press_mask[7] = 1'b0;
    repeat (4) @(negedge clk);
    press_mask[7] = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("chat_still_held", 32'(key_held), 32'd1);
    check_eq("chat_no_second", 32'(n_valid - v0), 32'd1);
    press_mask[7] = 1'b0;
    wait_held(1'b0, 100, "chat_clr");
    check_eq("chat_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset while a key is held: state and digits clear, key is re-debounced.
    v0 = n_valid;
    push_key(4'd9);
    @(negedge clk);
    press_mask[9] = 1'b1;
    wait_held(1'b1, 200, "rst_key_held");
    check_eq("pre_rst_digits", 32'(w_digits), 32'h00000479);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst2_col", 32'(col_out), 32'h0000000E);
    check_eq("rst2_held", 32'(key_held), 32'd0);
    check_eq("rst2_code", 32'(key_code), 32'd0);
    check_eq("rst2_digits", 32'(w_digits), 32'd0);
    m_digits = 16'd0;
    sb_q.delete();
    push_key(4'd9);
    @(negedge clk);
    rst = 1'b1;
    wait_held(1'b1, 200, "rst_rehold");
    repeat (20) @(negedge clk);
    press_mask[9] = 1'b0;
    wait_held(1'b0, 100, "rst_release");
    check_eq("rst_valid_twice", 32'(n_valid - v0), 32'd2);
    check_eq("rst_final_digits", 32'(w_digits), 32'h00000009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
